// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the SRAM bus arbiter.
//   state_t  - arbiter FSM states
//   grant_t  - which requester owns the access in flight
//   op_t     - read or write access
//   DEFAULT_ACCESS_CYCLES - default oe_n/we_n active time in cycles
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        DONE
    } state_t;

    typedef enum logic {
        GNT_IF,
        GNT_MEM
    } grant_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    localparam int DEFAULT_ACCESS_CYCLES = 2;

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable 4-bit down counter that stops at zero.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset, clears the count
//   load       in   load load_value (has priority over en)
//   en         in   decrement by one while non-zero
//   load_value in   4-bit value to load
//   zero       out  count == 0
module mem_wait_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       en,
    input  logic [3:0] load_value,
    output logic       zero
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one asynchronous SRAM between instruction fetch
// (IF, read-only) and the MEM stage (load/store), sequencing SRAM timing with
// an FSM and producing one-cycle acks plus pipeline stall signals.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   if_req_i/if_addr_i       fetch request and address
//   if_rdata_o/if_ack_o      fetched word, one-cycle completion
//   mem_read_i/mem_write_i   load/store request (both high = store)
//   mem_addr_i/mem_wdata_i   load/store address and store data
//   mem_rdata_o/mem_ack_o    load data, one-cycle completion
//   stall_if_o/stall_pipe_o  freeze signals for the hazard unit
//   sram_*                   SRAM address, data, tristate enable, strobes
//
// Optional build macro MEM_ARB_RR_EN: when defined, simultaneous requests
// alternate via a last_grant register instead of fixed MEM priority.
//
// Handshake: a requester raises its request and holds it, with stable
// address/data, until it sees its ack high for one cycle; it advances on the
// ack edge. The arbiter samples request fields once, at grant, so the access
// in flight is unaffected by later input changes. A request still high in
// the IDLE after DONE counts as a new request.
//
// ACCESS_CYCLES must be within 1..15 (4-bit wait counter).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = 16,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int ACCESS_CYCLES   = DEFAULT_ACCESS_CYCLES
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_req_i,
    input  logic [ADDRESS_WIDTH-1:0]   if_addr_i,
    output logic [ADDRESS_WIDTH-1:0]   if_rdata_o,
    output logic                       if_ack_o,
    input  logic                       mem_read_i,
    input  logic                       mem_write_i,
    input  logic [ADDRESS_WIDTH-1:0]   mem_addr_i,
    input  logic [ADDRESS_WIDTH-1:0]   mem_wdata_i,
    output logic [ADDRESS_WIDTH-1:0]   mem_rdata_o,
    output logic                       mem_ack_o,
    output logic                       stall_if_o,
    output logic                       stall_pipe_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [ADDRESS_WIDTH-1:0]   sram_dq_o,
    input  logic [ADDRESS_WIDTH-1:0]   sram_dq_i,
    output logic                       sram_dq_oe_o,
    output logic                       sram_ce_n_o,
    output logic                       sram_oe_n_o,
    output logic                       sram_we_n_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(ACCESS_CYCLES - 1);

    state_t                   state;
    state_t                   state_next;
    grant_t                   gnt_q;
    grant_t                   gnt_sel;
    op_t                      op_q;
    op_t                      op_sel;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH-1:0] wdata_q;
    logic [ADDRESS_WIDTH-1:0] if_rdata_q;
    logic [ADDRESS_WIDTH-1:0] mem_rdata_q;
    logic                     mem_req;
    logic                     req_any;
    logic                     cnt_load;
    logic                     cnt_en;
    logic                     cnt_zero;

    assign mem_req = mem_read_i | mem_write_i;
    assign req_any = mem_req | if_req_i;

`ifdef MEM_ARB_RR_EN
    grant_t last_grant_q;

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt_sel = GNT_IF;
        if (mem_req && if_req_i) begin
            gnt_sel = (last_grant_q == GNT_MEM) ? GNT_IF : GNT_MEM;
        end else if (mem_req) begin
            gnt_sel = GNT_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= GNT_IF;
        end else if (state == IDLE && req_any) begin
            last_grant_q <= gnt_sel;
        end
    end
`else
    always_comb begin
        gnt_sel = mem_req ? GNT_MEM : GNT_IF;
    end
`endif

    // Read+write together from MEM is a store.
    assign op_sel = (gnt_sel == GNT_MEM && mem_write_i) ? OP_WR : OP_RD;

    // The counter is reloaded in the state before each timed state, so it
    // holds ACCESS_CYCLES-1 on entry to RD / WR_PULSE.
    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_load = 1'b1;
                if (req_any) begin
                    state_next = (op_sel == OP_WR) ? WR_SETUP : RD;
                end
            end
            RD: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_next = DONE;
            end
            WR_SETUP: begin
                cnt_load   = 1'b1;
                state_next = WR_PULSE;
            end
            WR_PULSE: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            gnt_q       <= GNT_IF;
            op_q        <= OP_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_any) begin
                gnt_q   <= gnt_sel;
                op_q    <= op_sel;
                addr_q  <= (gnt_sel == GNT_MEM) ? mem_addr_i : if_addr_i;
                wdata_q <= mem_wdata_i;
            end
            // Capture on the final RD edge, while oe_n is still asserted.
            if (state == RD && cnt_zero) begin
                if (gnt_q == GNT_MEM) mem_rdata_q <= sram_dq_i;
                else                  if_rdata_q  <= sram_dq_i;
            end
        end
    end

    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .en         (cnt_en),
        .load_value (WAIT_LOAD),
        .zero       (cnt_zero)
    );

    assign if_ack_o     = (state == DONE) && (gnt_q == GNT_IF);
    assign mem_ack_o    = (state == DONE) && (gnt_q == GNT_MEM);
    assign if_rdata_o   = if_rdata_q;
    assign mem_rdata_o  = mem_rdata_q;
    assign stall_if_o   = if_req_i & ~if_ack_o;
    assign stall_pipe_o = mem_req & ~mem_ack_o;

    // dq stays driven through DONE after a write to give the SRAM hold time.
    assign sram_dq_oe_o = (state == WR_SETUP) || (state == WR_PULSE) ||
                          ((state == DONE) && (op_q == OP_WR));
    assign sram_dq_o    = sram_dq_oe_o ? wdata_q : '0;
    assign sram_addr_o  = SRAM_ADDR_WIDTH'(addr_q);
    assign sram_ce_n_o  = (state == IDLE);
    assign sram_oe_n_o  = (state != RD);
    assign sram_we_n_o  = (state != WR_PULSE);

endmodule
